fipo_load_ctrl: RTL and testbench
=================================

Name: fipo_load_ctrl

Overview:
- Sequencer that fills the 312-bit serial-in/parallel-out weight/config memory of the RSNN from the byte-wide chip input bus.
- Accepts bytes over a valid/ready handshake and serializes each byte LSB-first onto the memory's enable/serial_in pins.
- Checks the memory's per-bit write acknowledges and its end-of-write pulse, then raises a sticky cfg_done that releases the network core.
- Flags protocol mismatches as a sticky error.

Parameters:
- TOTAL_BITS, 312, bits in the target memory; must be a multiple of BYTE_W.
- BYTE_W, 8, width of the input byte bus.
- END_TIMEOUT, 4, cycles allowed in WAIT_END for the memory's end-of-write pulse.
- NUM_BYTES is local, TOTAL_BITS/BYTE_W (39).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a load session; ignored while busy.
- in_data  in  BYTE_W  config byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  controller can accept a byte.
- mem_enable  out  1  drives the memory enable pin (registered).
- mem_serial_in  out  1  drives the memory serial_in pin (registered).
- mem_data_written  in  1  per-bit write acknowledge from the memory.
- mem_end_writing  in  1  end-of-write pulse from the memory.
- busy  out  1  a session is in progress.
- cfg_done  out  1  sticky: memory loaded and verified.
- error  out  1  sticky: protocol mismatch detected.
- bytes_loaded  out  6  number of bytes accepted in the current session.

Behaviour:
- Reset (async): state=IDLE. All outputs 0: in_ready, mem_enable, mem_serial_in, busy, cfg_done, error, bytes_loaded. Shift register, bit counter, ack counter and timeout counter cleared.
- A byte transfers on a cycle with in_valid && in_ready. in_ready is 1 only in LOAD. in_data is ignored otherwise.
- IDLE, DONE, ERR: start -> LOAD. On that transition clear cfg_done, error, bytes_loaded and ack_cnt; set busy=1.
- LOAD:
  - On transfer, latch in_data into shreg, increment bytes_loaded, go to SHIFT.
  - With no transfer, wait indefinitely with mem_enable=0.
- SHIFT: for BYTE_W consecutive cycles drive mem_enable=1 and mem_serial_in=shreg[0]; shift shreg right each cycle.
  - After bit BYTE_W-1: go to LOAD if bytes_loaded<NUM_BYTES, else FINISH.
  - A new byte is never accepted while shifting.
  - Throughput is 9 cycles per byte with in_valid held high.
- FINISH: one cycle with mem_enable=1, mem_serial_in=0. This wraps the memory counter and triggers its end-of-write pulse. Then go to WAIT_END.
- WAIT_END:
  - mem_enable=0; count cycles.
  - On mem_end_writing with ack_cnt==TOTAL_BITS -> DONE: cfg_done=1, busy=0.
  - On mem_end_writing with ack_cnt!=TOTAL_BITS, or after END_TIMEOUT cycles without the pulse -> ERR: error=1, busy=0.
- ack_cnt (9 bits, saturating at 511) increments on every mem_data_written pulse in any busy state.
- mem_end_writing seen in LOAD, SHIFT or FINISH -> ERR immediately. This covers memory not at count 0 at session start.
- cfg_done and error are mutually exclusive; each holds until the next start or rst.
- start while busy has no effect.
- rst mid-session aborts immediately to IDLE with all outputs cleared. The memory shares rst, so it restarts at bit 0.
- Bit ordering: byte k bit i lands at memory bit 8k+i.

Decomposition:
- Shared package rsnn_cfg_pkg holds:
  - TOTAL_BITS=312 and BYTE_W=8.
  - State enum {IDLE, LOAD, SHIFT, FINISH, WAIT_END, DONE, ERR}.
- No sub-module: a single FSM with a shift register and counters.
- The testbench instantiates this block together with the memory.

Test Plan:
- Nominal load: rst, start, 39 bytes of 0xA5 with in_valid held high -> parallel_out = 39 repetitions of 0xA5. cfg_done=1 no later than 356 cycles after start. error=0, bytes_loaded=39, ack_cnt=312.
- Ordering and backpressure: bytes 0x00..0x26 with in_valid deasserted for 3 random cycles between bytes -> parallel_out[8k+7:8k]=k for all k. in_ready is never high during SHIFT.
- Start ignored while busy: pulse start during byte 10 -> no restart, bytes_loaded continues to 39, cfg_done=1.
- Reset mid-session: assert rst after byte 20 -> all outputs 0 on the same cycle. A new session of 39 bytes of 0xFF completes with parallel_out all ones and cfg_done=1.
- Missing end pulse: force mem_end_writing=0 -> error=1 exactly END_TIMEOUT cycles after FINISH, cfg_done=0, busy=0.
- Early end pulse and recovery: inject a mem_end_writing pulse during SHIFT -> ERR next cycle, error=1. A following start clears error and a full nominal reload reaches cfg_done=1.

Source files
------------

// File: rtl/rsnn_cfg_pkg.sv
// rtl/rsnn_cfg_pkg.sv - shared sizes and loader FSM state type for the RSNN config memory
package rsnn_cfg_pkg;

  localparam int TOTAL_BITS = 312;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FINISH,
    WAIT_END,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/fipo_load_ctrl.sv
// rtl/fipo_load_ctrl.sv - byte-to-serial loader for the RSNN SIPO weight/config memory
module fipo_load_ctrl #(
  parameter int TOTAL_BITS  = rsnn_cfg_pkg::TOTAL_BITS,
  parameter int BYTE_W      = rsnn_cfg_pkg::BYTE_W,
  parameter int END_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_enable,
  output logic              mem_serial_in,
  input  logic              mem_data_written,
  input  logic              mem_end_writing,
  output logic              busy,
  output logic              cfg_done,
  output logic              error,
  output logic [5:0]        bytes_loaded
);
  import rsnn_cfg_pkg::*;

  localparam int NUM_BYTES = TOTAL_BITS / BYTE_W;
  localparam int BIT_W     = $clog2(BYTE_W);
  localparam int TMO_W     = $clog2(END_TIMEOUT + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BYTE_W-1:0]  r_shreg;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [8:0]         r_ack_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [5:0]         r_bytes_loaded;
  logic               r_cfg_done;
  logic               r_error;
  logic               r_mem_enable;
  logic               r_mem_serial_in;
  logic               w_busy;
  logic               w_xfer;
  logic               w_start_go;
  logic               w_last_bit;

  assign w_busy     = (r_state == LOAD) || (r_state == SHIFT) ||
                      (r_state == FINISH) || (r_state == WAIT_END);
  assign w_xfer     = in_valid && (r_state == LOAD);
  assign w_start_go = start && !w_busy;
  assign w_last_bit = (r_bit_cnt == BIT_W'(BYTE_W - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start) w_state_nxt = LOAD;
      LOAD: begin
        if (mem_end_writing) w_state_nxt = ERR;
        else if (w_xfer)     w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (mem_end_writing) w_state_nxt = ERR;
        else if (w_last_bit)
          w_state_nxt = (r_bytes_loaded < 6'(NUM_BYTES)) ? LOAD : FINISH;
      end
      FINISH: w_state_nxt = mem_end_writing ? ERR : WAIT_END;
      WAIT_END: begin
        if (mem_end_writing)
          w_state_nxt = (r_ack_cnt == 9'(TOTAL_BITS)) ? DONE : ERR;
        else if (r_tmo_cnt == TMO_W'(END_TIMEOUT - 1))
          w_state_nxt = ERR;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory pins are registered from the next state so they line up with SHIFT/FINISH cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_shreg         <= '0;
      r_bit_cnt       <= '0;
      r_ack_cnt       <= '0;
      r_tmo_cnt       <= '0;
      r_bytes_loaded  <= '0;
      r_cfg_done      <= 1'b0;
      r_error         <= 1'b0;
      r_mem_enable    <= 1'b0;
      r_mem_serial_in <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_mem_enable    <= (w_state_nxt == SHIFT) || (w_state_nxt == FINISH);
      r_mem_serial_in <= 1'b0;
      if (w_state_nxt == SHIFT)
        r_mem_serial_in <= (r_state == SHIFT) ? r_shreg[1] : in_data[0];

      if (w_xfer) begin
        r_shreg        <= in_data;
        r_bytes_loaded <= r_bytes_loaded + 6'd1;
      end else if (r_state == SHIFT) begin
        r_shreg <= r_shreg >> 1;
      end

      r_bit_cnt <= (r_state == SHIFT) ? r_bit_cnt + 1'b1 : '0;
      r_tmo_cnt <= (r_state == WAIT_END) ? r_tmo_cnt + 1'b1 : '0;

      if (w_start_go) begin
        r_cfg_done     <= 1'b0;
        r_error        <= 1'b0;
        r_bytes_loaded <= '0;
        r_ack_cnt      <= '0;
      end else if (w_busy && mem_data_written && (r_ack_cnt != 9'h1FF)) begin
        r_ack_cnt <= r_ack_cnt + 9'd1;
      end

      if ((r_state == WAIT_END) && (w_state_nxt == DONE)) r_cfg_done <= 1'b1;
      if (w_busy && (w_state_nxt == ERR))                 r_error    <= 1'b1;
    end
  end

  assign in_ready      = (r_state == LOAD);
  assign busy          = w_busy;
  assign mem_enable    = r_mem_enable;
  assign mem_serial_in = r_mem_serial_in;
  assign cfg_done      = r_cfg_done;
  assign error         = r_error;
  assign bytes_loaded  = r_bytes_loaded;

endmodule

// File: tb/tb_fipo_load_ctrl.sv
// tb/tb_fipo_load_ctrl.sv - bench for fipo_load_ctrl with a behavioural SIPO memory
module tb_fipo_load_ctrl;

  localparam int TB_BITS = 312;
  localparam int NB      = 39;
  localparam int ET      = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_enable;
  logic       mem_serial_in;
  logic       mem_data_written;
  logic       mem_end_writing;
  logic       busy;
  logic       cfg_done;
  logic       error;
  logic [5:0] bytes_loaded;

  fipo_load_ctrl #(.TOTAL_BITS(TB_BITS), .BYTE_W(8), .END_TIMEOUT(ET)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .mem_enable       (mem_enable),
    .mem_serial_in    (mem_serial_in),
    .mem_data_written (mem_data_written),
    .mem_end_writing  (mem_end_writing),
    .busy             (busy),
    .cfg_done         (cfg_done),
    .error            (error),
    .bytes_loaded     (bytes_loaded)
  );

  always #5 clk = ~clk;

  // Memory model: writes one bit per enable, wraps at TB_BITS with an end pulse.
  logic [TB_BITS-1:0] mem_q;
  logic [8:0]         mem_cnt;
  logic               mem_dw, mem_end_raw;
  logic               mem_clr = 1'b0, end_mask = 1'b0, end_inject = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0; mem_cnt <= '0; mem_dw <= 1'b0; mem_end_raw <= 1'b0;
    end else begin
      mem_dw      <= 1'b0;
      mem_end_raw <= 1'b0;
      if (mem_clr) begin
        mem_cnt <= '0;
      end else if (mem_enable) begin
        if (mem_cnt == 9'(TB_BITS)) begin
          mem_cnt     <= '0;
          mem_end_raw <= 1'b1;
        end else begin
          mem_q[mem_cnt] <= mem_serial_in;
          mem_cnt        <= mem_cnt + 9'd1;
          mem_dw         <= 1'b1;
        end
      end
    end
  end

  assign mem_data_written = mem_dw;
  assign mem_end_writing  = (mem_end_raw & ~end_mask) | end_inject;

  // Scoreboard: accepted bytes push their bits LSB-first, enabled cycles pop them.
  int cyc = 0;
  int en_cnt = 0, fin_cyc = 0, bit_errs = 0;
  bit rdy_bad = 1'b0;
  bit exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (rst || (start && !busy)) begin
      en_cnt <= 0; bit_errs <= 0; rdy_bad <= 1'b0;
      exp_q.delete();
    end else begin
      if (mem_enable) begin
        en_cnt <= en_cnt + 1;
        if (en_cnt < TB_BITS) begin
          if (exp_q.size() == 0)                     bit_errs <= bit_errs + 1;
          else if (exp_q.pop_front() !== mem_serial_in) bit_errs <= bit_errs + 1;
        end else if (en_cnt == TB_BITS) begin
          fin_cyc <= cyc;
        end
        if (in_ready) rdy_bad <= 1'b1;
      end
      if (in_valid && in_ready)
        for (int i = 0; i < 8; i++) exp_q.push_back(in_data[i]);
    end
  end

  typedef struct {
    string      name;
    bit         incr;
    logic [7:0] val;
    int         max_gap;
    int         start_at;
    bit         mask_end;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs[5];
  vec_t v_ff, v_nom;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    in_valid = 1'b0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    repeat (gap) @(negedge clk);
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~b;
  endtask

  task automatic run_session(input vec_t v);
    int               lat_start, done_cyc, gap, waited;
    logic [TB_BITS-1:0] exp_mem;
    logic [7:0]       b;
    exp_mem  = '0;
    end_mask = v.mask_end;
    @(negedge clk);
    start = 1'b1; lat_start = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, ".start_state"}, 64'({busy, cfg_done, error, bytes_loaded}), 64'({1'b1, 1'b0, 1'b0, 6'd0}));
    for (int k = 0; k < NB; k++) begin
      b = v.incr ? 8'(k) : v.val;
      exp_mem[8*k +: 8] = b;
      gap = (v.max_gap > 0 && k > 0) ? int'($urandom_range(v.max_gap, 1)) : 0;
      send_byte(b, gap);
      if (k == v.start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({v.name, ".start_ignored"}, 64'({busy, bytes_loaded}), 64'({1'b1, 6'(k + 1)}));
      end
    end
    waited = 0;
    while (!(cfg_done || error) && waited < 100) begin @(negedge clk); waited++; end
    done_cyc = cyc;
    chk({v.name, ".end_reached"}, 64'(cfg_done | error), 64'd1);
    chk({v.name, ".cfg_done"}, 64'(cfg_done), 64'(v.exp_done));
    chk({v.name, ".error"}, 64'(error), 64'(v.exp_err));
    chk({v.name, ".busy"}, 64'(busy), 64'd0);
    chk({v.name, ".bytes_loaded"}, 64'(bytes_loaded), 64'(NB));
    chk({v.name, ".ack_cnt"}, 64'(dut.r_ack_cnt), 64'(TB_BITS));
    chk({v.name, ".serial_bit_errors"}, 64'(bit_errs), 64'd0);
    chk({v.name, ".ready_in_shift"}, 64'(rdy_bad), 64'd0);
    n_tests++;
    if (mem_q !== exp_mem) begin
      n_fail++;
      $display("FAIL %s.parallel_out: got %h expected %h", v.name, mem_q, exp_mem);
    end
    if (v.mask_end)
      chk({v.name, ".timeout_cycles"}, 64'(done_cyc - fin_cyc), 64'(ET + 1));
    else if (v.max_gap == 0 && v.start_at < 0)
      chk({v.name, ".latency_le_356"}, 64'((done_cyc - lat_start) <= 356), 64'd1);
    end_mask = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"nominal_a5",   1'b0, 8'hA5, 0, -1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"incr_gaps",    1'b1, 8'h00, 3, -1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"start_busy",   1'b0, 8'h3C, 0, 10, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"zeros_gaps",   1'b0, 8'h00, 2, -1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"no_end_pulse", 1'b0, 8'h5A, 0, -1, 1'b1, 1'b0, 1'b1};
    v_ff    = '{"ones_after_rst", 1'b0, 8'hFF, 0, -1, 1'b0, 1'b1, 1'b0};
    v_nom   = '{"reload_after_err", 1'b0, 8'hA5, 0, -1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        64'({in_ready, mem_enable, mem_serial_in, busy, cfg_done, error, bytes_loaded}), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_session(vecs[i]);

    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20; k++) send_byte(8'h11, 0);
    chk("rst_mid_pre", 64'({busy, bytes_loaded}), 64'({1'b1, 6'd20}));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outputs",
        64'({in_ready, mem_enable, mem_serial_in, busy, cfg_done, error, bytes_loaded}), 64'd0);
    @(negedge clk); rst = 1'b0;
    run_session(v_ff);

    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 5; k++) send_byte(8'h0F, 0);
    chk("early_pre_busy", 64'({busy, mem_enable}), 64'({1'b1, 1'b1}));
    end_inject = 1'b1;
    @(negedge clk);
    end_inject = 1'b0;
    chk("early_end_err", 64'({error, busy, cfg_done, mem_enable}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    run_session(v_nom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
